// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader: FSM state encoding and
// output-buffer sizing.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Two entries cover one word being presented plus one read in flight.
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 2;

endpackage

// File: rtl/ram_stream_reader_buf.sv
// Two-entry FIFO holding read words (and, with RAM_STREAM_READER_LAST_EN, an
// end-of-command flag) between the RAM read port and the output stream.
module ram_stream_reader_buf
    import ram_stream_reader_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WORD_WIDTH-1:0] push_data_i,
`ifdef RAM_STREAM_READER_LAST_EN
    input  logic                  push_last_i,
    output logic                  head_last_o,
`endif
    input  logic                  pop_i,
    output logic [WORD_WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [WORD_WIDTH-1:0] data_q [BUF_DEPTH];
    logic [WORD_WIDTH-1:0] data_d [BUF_DEPTH];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
`ifdef RAM_STREAM_READER_LAST_EN
    logic [BUF_DEPTH-1:0]  last_q, last_d;
`endif

    always_comb begin
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
`ifdef RAM_STREAM_READER_LAST_EN
        last_d   = last_q;
`endif
        if (push_i) begin
            data_d[wr_ptr_q] = push_data_i;
`ifdef RAM_STREAM_READER_LAST_EN
            last_d[wr_ptr_q] = push_last_i;
`endif
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    // Payload storage carries no reset; only pointers and occupancy do.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
        data_q <= data_d;
`ifdef RAM_STREAM_READER_LAST_EN
        last_q <= last_d;
`endif
    end

    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;
`ifdef RAM_STREAM_READER_LAST_EN
    assign head_last_o = last_q[rd_ptr_q];
`endif

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a (start, length) range out of a 1-cycle-latency single-port RAM onto
// a valid/ready interface. Define RAM_STREAM_READER_LAST_EN to add m_last_o.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter  int WORD_WIDTH = 8,
    parameter  int WORD_COUNT = 256,
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT),
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [WORD_WIDTH-1:0] ram_rdata_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WORD_WIDTH-1:0] m_data_o,
`ifdef RAM_STREAM_READER_LAST_EN
    output logic                  m_last_o,
`endif
    output logic                  busy_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
`ifdef RAM_STREAM_READER_LAST_EN
    logic                  inflight_last_q, inflight_last_d;
`endif

    logic [CNT_W-1:0]      buf_count;
    logic [CNT_W:0]        occupancy;
    logic                  pop;
    logic                  issue;
    logic                  cmd_fire;

    assign cmd_ready_o = (state_q == IDLE);
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign m_valid_o   = (buf_count != '0);
    assign pop         = m_valid_o && m_ready_i;
    assign occupancy   = {1'b0, buf_count} + (CNT_W+1)'(inflight_q);

    // A slot freed by this cycle's pop can be reused by this cycle's read.
    assign issue = (state_q == READ) &&
                   (occupancy < ((CNT_W+1)'(BUF_DEPTH) + (CNT_W+1)'(pop)));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        ram_addr_d = ram_addr_q;
        inflight_d = issue;
`ifdef RAM_STREAM_READER_LAST_EN
        inflight_last_d = issue && (rem_q == LEN_WIDTH'(1));
`endif
        case (state_q)
            IDLE: begin
                if (cmd_fire && (cmd_len_i != '0)) begin
                    addr_d  = cmd_addr_i;
                    rem_d   = cmd_len_i;
                    state_d = READ;
                end
            end
            READ: begin
                if (issue) begin
                    ram_addr_d = addr_q;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    rem_d      = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && (buf_count == CNT_W'(pop))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clearing inflight_q on reset drops any read whose data is still in the RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            ram_addr_q <= '0;
`ifdef RAM_STREAM_READER_LAST_EN
            inflight_last_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            ram_addr_q <= ram_addr_d;
`ifdef RAM_STREAM_READER_LAST_EN
            inflight_last_q <= inflight_last_d;
`endif
        end
    end

    assign ram_addr_o = issue ? addr_q : ram_addr_q;
    assign ram_we_o   = 1'b0;
    assign busy_o     = (state_q != IDLE);

    ram_stream_reader_buf #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i (ram_rdata_i),
`ifdef RAM_STREAM_READER_LAST_EN
        .push_last_i (inflight_last_q),
        .head_last_o (m_last_o),
`endif
        .pop_i       (pop),
        .head_data_o (m_data_o),
        .count_o     (buf_count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a 1-cycle-latency RAM model
// preloaded with mem[i] = i.
module tb_ram_stream_reader;

    localparam int WW = 8;
    localparam int WC = 256;
    localparam int AW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_rdata = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [WW-1:0] m_data;
    logic          busy;
`ifdef RAM_STREAM_READER_LAST_EN
    logic          m_last;
`endif

    logic [WW-1:0] mem [WC];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_addr];

    ram_stream_reader #(
        .WORD_WIDTH (WW),
        .WORD_COUNT (WC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_rdata_i (ram_rdata),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
`ifdef RAM_STREAM_READER_LAST_EN
        .m_last_o    (m_last),
`endif
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        tick;
        cmd_valid = 1'b0;
    endtask

    // Pops n words, checking each against start+k (mod 256); returns cycles used.
    task automatic collect(input logic [AW-1:0] start, input int n, input bit toggle,
                           input int budget, output int cycles);
        int k = 0;
        logic [WW-1:0] e;
        cycles = 0;
        while (k < n && cycles < budget) begin
            m_ready = toggle ? ((cycles % 2) == 0) : 1'b1;
            if (m_valid && m_ready) begin
                e = start + AW'(k);
                chk("data", 32'(m_data), 32'(e));
`ifdef RAM_STREAM_READER_LAST_EN
                chk("last", 32'(m_last), 32'(k == n - 1));
`endif
                k++;
            end
            tick;
            cycles++;
        end
        if (k != n) chk("word_count", 32'(k), 32'(n));
        chk("done_valid", 32'(m_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < WC; i++) mem[i] = WW'(i);

        repeat (3) tick;
        rst = 1'b0;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
`ifdef RAM_STREAM_READER_LAST_EN
        chk("rst_m_last", 32'(m_last), 32'd0);
`endif

        // Basic 4-word read with downstream always ready.
        m_ready = 1'b1;
        send(8'h10, 9'd4);
        chk("t1_first_addr", 32'(ram_addr), 32'h10);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_no_early_valid", 32'(m_valid), 32'd0);
        collect(8'h10, 4, 1'b0, 20, cyc);
        chk("t1_cycles", 32'(cyc), 32'd6);

        // Address wrap.
        send(8'hFE, 9'd4);
        collect(8'hFE, 4, 1'b0, 20, cyc);
        chk("t2_cycles", 32'(cyc), 32'd6);

        // Toggling backpressure.
        send(8'h20, 9'd8);
        collect(8'h20, 8, 1'b1, 60, cyc);

        // Long stall: only two reads issue, then resume without a bubble.
        m_ready = 1'b0;
        send(8'h40, 9'd5);
        chk("t4_addr0", 32'(ram_addr), 32'h40);
        tick;
        chk("t4_addr1", 32'(ram_addr), 32'h41);
        repeat (9) tick;
        chk("t4_stall_addr", 32'(ram_addr), 32'h41);
        chk("t4_stall_valid", 32'(m_valid), 32'd1);
        chk("t4_stall_data", 32'(m_data), 32'h40);
        collect(8'h40, 5, 1'b0, 20, cyc);
        chk("t4_cycles", 32'(cyc), 32'd5);

        // Zero-length command.
        send(8'h33, 9'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t5_valid0", 32'(m_valid), 32'd0);
        tick;
        chk("t5_valid1", 32'(m_valid), 32'd0);

        // Full RAM from 0x80.
        send(8'h80, 9'd256);
        collect(8'h80, 256, 1'b0, 300, cyc);
        chk("t6_cycles", 32'(cyc), 32'd258);

        // Reset in the middle of a stream, then a fresh short command.
        m_ready = 1'b1;
        send(8'h50, 9'd16);
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t7_valid", 32'(m_valid), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_cmd_ready", 32'(cmd_ready), 32'd1);
        send(8'hA0, 9'd2);
        collect(8'hA0, 2, 1'b0, 20, cyc);
        chk("t7_cycles", 32'(cyc), 32'd4);
        repeat (3) tick;
        chk("t7_no_stale", 32'(m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
